// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential non-restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int DIV_N     = 8;
  localparam int DIV_CNT_W = $clog2(DIV_N + 1);

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/seq_nonrestoring_divider_nr_div_step.sv
// One non-restoring iteration: shift in the next dividend bit, then add or
// subtract the divisor magnitude depending on the sign of the partial remainder.
module nr_div_step
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N:0]   p,
  input  logic         din,
  input  logic [N-1:0] dvr,
  output logic [N:0]   p_new,
  output logic         q_bit
);

  logic [N:0] shifted_s;

  // Shift, then subtract on non-negative or add on negative partial remainder
  always_comb begin
    shifted_s = {p[N-1:0], din};
    if (p[N] == 1'b0) begin
      p_new = shifted_s - {1'b0, dvr};
    end else begin
      p_new = shifted_s + {1'b0, dvr};
    end
    q_bit = ~p_new[N];
  end

endmodule

// File: rtl/seq_nonrestoring_divider.sv
// Signed 2N/N sequential divider: magnitude non-restoring iteration over N
// cycles, then one cycle that restores the remainder and applies signs/flags.
module seq_nonrestoring_divider
  import div_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           START,
  input  logic [2*N-1:0] DVD,
  input  logic [N-1:0]   DVR,
  output logic           BUSY,
  output logic           DONE,
  output logic [N-1:0]   Q,
  output logic [N-1:0]   R,
  output logic           DZ,
  output logic           OVF
);

  localparam int            CW      = cnt_width(N);
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] LAST    = CW'(N - 1);
  localparam logic [N-1:0]  HALF    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  HALF_M1 = {1'b0, {(N-1){1'b1}}};

  state_t        state_r;
  logic          sa_r;
  logic          sb_r;
  logic          dz_r;
  logic          pov_r;
  logic [N-1:0]  dvr_r;
  logic [N:0]    p_r;
  logic [N-1:0]  q_r;
  logic [CW-1:0] cnt_r;

  logic [2*N-1:0] abs_dvd_s;
  logic [N-1:0]   abs_dvr_s;
  logic           pov_s;
  logic [N:0]     step_p_s;
  logic           step_q_s;
  logic [N:0]     rfull_s;
  logic [N-1:0]   rmag_s;
  logic           neg_s;
  logic           post_ovf_s;
  logic [N-1:0]   q_fix_s;
  logic [N-1:0]   r_fix_s;

  nr_div_step #(.N(N)) u_step (
    .p     (p_r),
    .din   (q_r[N-1]),
    .dvr   (dvr_r),
    .p_new (step_p_s),
    .q_bit (step_q_s)
  );

  // Operand magnitudes, pre-check and the sign-fix results
  always_comb begin
    abs_dvd_s = DVD[2*N-1] ? -DVD : DVD;
    abs_dvr_s = DVR[N-1] ? -DVR : DVR;
    pov_s     = (abs_dvd_s[2*N-1:N] >= abs_dvr_s);
    if (p_r[N]) begin
      rfull_s = p_r + {1'b0, dvr_r};
    end else begin
      rfull_s = p_r;
    end
    rmag_s     = rfull_s[N-1:0];
    neg_s      = sa_r ^ sb_r;
    post_ovf_s = neg_s ? (q_r > HALF) : (q_r > HALF_M1);
    q_fix_s    = neg_s ? -q_r : q_r;
    r_fix_s    = sa_r ? -rmag_s : rmag_s;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      sa_r    <= 1'b0;
      sb_r    <= 1'b0;
      dz_r    <= 1'b0;
      pov_r   <= 1'b0;
      dvr_r   <= {N{1'b0}};
      p_r     <= {(N+1){1'b0}};
      q_r     <= {N{1'b0}};
      cnt_r   <= {CW{1'b0}};
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      Q       <= {N{1'b0}};
      R       <= {N{1'b0}};
      DZ      <= 1'b0;
      OVF     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            sa_r    <= DVD[2*N-1];
            sb_r    <= DVR[N-1];
            dvr_r   <= abs_dvr_s;
            p_r     <= {1'b0, abs_dvd_s[2*N-1:N]};
            q_r     <= abs_dvd_s[N-1:0];
            dz_r    <= (DVR == {N{1'b0}});
            pov_r   <= pov_s;
            cnt_r   <= {CW{1'b0}};
            BUSY    <= 1'b1;
            DZ      <= 1'b0;
            OVF     <= 1'b0;
            state_r <= ITER;
          end
        end
        ITER: begin
          p_r   <= step_p_s;
          q_r   <= {q_r[N-2:0], step_q_s};
          cnt_r <= cnt_r + CNT_ONE;
          if (cnt_r == LAST) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          DONE    <= 1'b1;
          BUSY    <= 1'b0;
          state_r <= IDLE;
          if (dz_r) begin
            DZ  <= 1'b1;
            OVF <= 1'b0;
            Q   <= {N{1'b0}};
            R   <= {N{1'b0}};
          end else if (pov_r || post_ovf_s) begin
            DZ  <= 1'b0;
            OVF <= 1'b1;
            Q   <= {N{1'b0}};
            R   <= {N{1'b0}};
          end else begin
            DZ  <= 1'b0;
            OVF <= 1'b0;
            Q   <= q_fix_s;
            R   <= r_fix_s;
          end
        end
        default: begin
          state_r <= IDLE;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_nonrestoring_divider.md
Name: seq_nonrestoring_divider

Overview:
- Sequential signed divider, the inverse of the team's 8x8 sequential Booth multiplier.
- Divides a 2N-bit signed dividend by an N-bit signed divisor, giving an N-bit quotient and an N-bit remainder.
- Core is a non-restoring iteration on operand magnitudes, then one sign-fix cycle.
- Sits beside the multiplier in the lab ALU datapath; start/done handshake, fixed latency.

Parameters:
- N, 8, divisor/quotient/remainder width. Dividend width is 2N.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset: synchronous, active-high.
- START  in  1  one-cycle request; sampled only while BUSY=0.
- DVD  in  2N  signed dividend (two's complement).
- DVR  in  N  signed divisor (two's complement).
- BUSY  out  1  high from the edge after an accepted START through the sign-fix cycle.
- DONE  out  1  one-cycle pulse; Q, R, DZ and OVF are valid from this cycle.
- Q  out  N  signed quotient, truncated toward zero.
- R  out  N  signed remainder; same sign as the dividend, or 0.
- DZ  out  1  divide-by-zero flag.
- OVF  out  1  quotient-overflow flag.

Behaviour:
- Reset: RST has priority over everything. Next edge forces state to IDLE and clears BUSY, DONE, Q, R, DZ and OVF to 0, along with all internal registers. RST mid-operation aborts the operation with no DONE pulse.
- States: IDLE, ITER, FIX.
- IDLE:
  - On an edge with START=1 (call it edge 0), register sA=DVD[2N-1] and sB=DVR[N-1].
  - Register |DVD| as a 2N-bit unsigned value; -2^(2N-1) maps to 0x8000 when N=8.
  - Register |DVR| as N bits unsigned.
  - Compute dz=(DVR==0) and pre-overflow pov=(|DVD|[2N-1:N] >= |DVR|).
  - Clear count, set BUSY=1, go to ITER.
- ITER: exactly N edges (edges 1..N).
  - Partial remainder P is N+1 bits signed. {P, Qreg} shifts left one bit each edge.
  - If P>=0 then P=P-|DVR|, else P=P+|DVR|.
  - The new quotient LSB is ~P_new[N].
  - Iterations run even when dz or pov is set; the results are discarded.
- FIX: edge N+1.
  - If P<0, add |DVR| to get the true remainder magnitude.
  - Q = sA^sB ? -Qmag : Qmag.
  - R = sA ? -Rmag : Rmag.
  - Post-overflow: Qmag > 2^(N-1)-1 with a positive result, or Qmag > 2^(N-1) with a negative result.
  - If dz: DZ=1, OVF=0, Q=0, R=0.
  - Else if pov or post-overflow: OVF=1, Q=0, R=0.
  - Assert DONE, clear BUSY, return to IDLE.
- DONE drops on the next edge. Q, R, DZ and OVF hold until the next accepted START or RST.
- On an accepted START, DZ and OVF clear at edge 0; Q and R keep their old values until FIX.
- Latency: START at edge 0 gives DONE high after edge N+1 (9 for N=8), every operation. Throughput is one division per N+2 cycles (START is allowed in the cycle DONE is high).
- START while BUSY=1 is ignored; the operand inputs are not re-sampled.
- Remainder magnitude is always < |DVR| <= 2^(N-1) magnitude, so R never overflows.

Decomposition:
- Package div_pkg holds:
  - the state enum {IDLE, ITER, FIX};
  - localparam DIV_N=8;
  - the count width $clog2(N+1).
- One natural combinational sub-module, nr_div_step. Inputs: P, next dividend bit, |DVR|. Outputs: P_new, q_bit. It is instantiated once and reused each ITER cycle.

Test Plan:
- 100 / 7 (DVD=0x0064, DVR=0x07) -> DONE 9 cycles after START; Q=0x0E (14), R=0x02, DZ=0, OVF=0.
- -100 / 7 (0xFF9C, 0x07) -> Q=0xF2 (-14), R=0xFE (-2). 100 / -7 (0x0064, 0xF9) -> Q=0xF2, R=0x02. -100 / -7 -> Q=0x0E, R=0xFE.
- Range limits:
  - -128 / 1 (0xFF80, 0x01) -> Q=0x80, R=0, OVF=0.
  - 128 / 1 (0x0080, 0x01) -> OVF=1, Q=0, R=0.
  - 16384 / 1 (0x4000, 0x01) -> OVF=1 via pre-check.
  - -32768 / -128 (0x8000, 0x80) -> Q=0x00 magnitude 256, OVF=1.
- 50 / 0 -> DONE at the same latency with DZ=1, OVF=0, Q=0, R=0. A following 9/3 clears DZ at its START edge and gives Q=3, R=0.
- START pulsed again 3 cycles into a 100/7 run with DVD=0x0010 -> ignored; result stays Q=14, R=2 with exactly one DONE pulse.
- RST asserted 4 cycles into an operation -> next edge BUSY=0, DONE never pulses, Q=R=0. A new START then completes normally.
